// File: rtl/crs_reg_bank_if.sv
// y-bus bundle between the crs master and a register-bank slave.
// The master drives address/data/strobe; the slave returns read data and the region hit.
interface crs_reg_bank_if #(
    parameter int ADR_W  = 12,
    parameter int DATA_W = 16
);
    logic [ADR_W-1:0]  y_adr;
    logic [DATA_W-1:0] y_wr_data;
    logic              y_wr;
    logic [DATA_W-1:0] y_rd_data;
    logic              hit;

    modport master (output y_adr, y_wr_data, y_wr, input y_rd_data, hit);
    modport slave  (input y_adr, y_wr_data, y_wr, output y_rd_data, hit);
endinterface

// File: rtl/crs_reg_bank.sv
// Parametrised y-bus register bank: control regs, live status, sticky events with IRQ,
// task strobes, key-based write-protect lock with timeout and a saturating write counter.
module crs_reg_bank #(
    parameter int                     ADR_W        = 12,
    parameter int                     DATA_W       = 16,
    parameter logic [ADR_W-1:0]       BASE_ADR     = ADR_W'('h8C0),
    parameter int                     N_CTRL       = 8,
    parameter int                     N_STAT       = 4,
    parameter logic [N_CTRL*DATA_W-1:0] CTRL_RST   = '0,
    parameter logic [N_CTRL-1:0]      PROT_MASK    = '0,
    parameter logic [15:0]            UNLOCK_KEY   = 16'hC0DE,
    parameter int                     LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    crs_reg_bank_if.slave              bus,
    output logic [N_CTRL*DATA_W-1:0]   ctrl_out,
    input  logic [N_STAT*DATA_W-1:0]   stat_in,
    input  logic [DATA_W-1:0]          sticky_set,
    output logic [DATA_W-1:0]          task_pulse,
    output logic                       irq,
    output logic                       unlocked
);
    localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [5:0] OFF_STICKY = 6'h20;
    localparam logic [5:0] OFF_MASK   = 6'h21;
    localparam logic [5:0] OFF_TASK   = 6'h22;
    localparam logic [5:0] OFF_LOCK   = 6'h23;
    localparam logic [5:0] OFF_CNT    = 6'h24;

    logic [5:0]  off;
    logic        in_region;
    logic        wr_en;
    logic        wr_sticky, wr_mask, wr_task, wr_lock, wr_cnt;
    logic        key_match;

    logic [DATA_W-1:0] ctrl_q [N_CTRL];
    logic [N_CTRL-1:0] ctrl_hit, ctrl_rej, ctrl_acc;

    logic [DATA_W-1:0] sticky_q, sticky_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] task_q;
    logic              irq_q;

    logic              unlocked_q, unlocked_d;
    logic              viol_q, viol_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              cnt_inc;
    logic [DATA_W-1:0] rd_data;

    assign off       = bus.y_adr[5:0];
    assign in_region = (bus.y_adr[ADR_W-1:6] == BASE_ADR[ADR_W-1:6]);
    assign wr_en     = bus.y_wr && in_region;
    assign wr_sticky = wr_en && (off == OFF_STICKY);
    assign wr_mask   = wr_en && (off == OFF_MASK);
    assign wr_task   = wr_en && (off == OFF_TASK);
    assign wr_lock   = wr_en && (off == OFF_LOCK);
    assign wr_cnt    = wr_en && (off == OFF_CNT);
    assign key_match = (bus.y_wr_data == DATA_W'(UNLOCK_KEY));

    genvar gi;
    generate
        for (gi = 0; gi < N_CTRL; gi++) begin : g_ctrl
            assign ctrl_hit[gi] = wr_en && (off == 6'(gi));
            assign ctrl_rej[gi] = ctrl_hit[gi] && PROT_MASK[gi] && !unlocked_q;
            assign ctrl_acc[gi] = ctrl_hit[gi] && !ctrl_rej[gi];
            assign ctrl_out[gi*DATA_W +: DATA_W] = ctrl_q[gi];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ctrl_q[gi] <= CTRL_RST[gi*DATA_W +: DATA_W];
                end else if (ctrl_acc[gi]) begin
                    ctrl_q[gi] <= bus.y_wr_data;
                end
            end
        end
    endgenerate

    // A simultaneous set beats the W1C clear because the OR is applied last.
    assign sticky_d = (sticky_q & ~(wr_sticky ? bus.y_wr_data : '0)) | sticky_set;
    assign mask_d   = wr_mask ? bus.y_wr_data : mask_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= '0;
            mask_q   <= '0;
            task_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            mask_q   <= mask_d;
            task_q   <= wr_task ? bus.y_wr_data : '0;
            irq_q    <= |(sticky_d & mask_d);
        end
    end

    // Protection is checked against the current lock state, so the last unlocked cycle still accepts.
    always_comb begin
        unlocked_d = unlocked_q;
        timer_d    = timer_q;
        viol_d     = viol_q || (|ctrl_rej);
        if (wr_lock) begin
            if (key_match) begin
                unlocked_d = 1'b1;
                timer_d    = TMR_W'(LOCK_TIMEOUT - 1);
            end else begin
                unlocked_d = 1'b0;
                viol_d     = 1'b0;
            end
        end else if (unlocked_q) begin
            if (timer_q == '0) begin
                unlocked_d = 1'b0;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            unlocked_q <= 1'b0;
            viol_q     <= 1'b0;
            timer_q    <= '0;
        end else begin
            unlocked_q <= unlocked_d;
            viol_q     <= viol_d;
            timer_q    <= timer_d;
        end
    end

    assign cnt_inc = (|ctrl_acc) || wr_sticky || wr_mask || wr_task || wr_lock;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_cnt) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_region) begin
            for (int i = 0; i < N_CTRL; i++) begin
                if (off == 6'(i)) rd_data = ctrl_q[i];
            end
            for (int j = 0; j < N_STAT; j++) begin
                if (off == 6'(16 + j)) rd_data = stat_in[j*DATA_W +: DATA_W];
            end
            case (off)
                OFF_STICKY: rd_data = sticky_q;
                OFF_MASK:   rd_data = mask_q;
                OFF_LOCK:   rd_data = {{(DATA_W-2){1'b0}}, viol_q, unlocked_q};
                OFF_CNT:    rd_data = cnt_q;
                default:    ;
            endcase
        end
    end

    assign bus.y_rd_data = rd_data;
    assign bus.hit       = in_region;
    assign task_pulse    = task_q;
    assign irq           = irq_q;
    assign unlocked      = unlocked_q;
endmodule

// File: tb/tb_crs_reg_bank.sv
// Directed bench for crs_reg_bank: the driver queues expected values per cycle,
// a negedge monitor pops and compares them against the live outputs.
module tb_crs_reg_bank;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] stat_in = 64'hD004_D003_D002_D001;
    logic [15:0] sticky_set;
    logic [127:0] ctrl_out;
    logic [15:0] task_pulse;
    logic        irq;
    logic        unlocked;

    always #5 clk = ~clk;

    crs_reg_bank_if #(.ADR_W(12), .DATA_W(16)) ybus ();

    crs_reg_bank #(
        .ADR_W(12), .DATA_W(16), .BASE_ADR(12'h8C0), .N_CTRL(8), .N_STAT(4),
        .CTRL_RST(128'h1234), .PROT_MASK(8'h01), .UNLOCK_KEY(16'hC0DE), .LOCK_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ybus), .ctrl_out(ctrl_out), .stat_in(stat_in),
        .sticky_set(sticky_set), .task_pulse(task_pulse), .irq(irq), .unlocked(unlocked)
    );

    typedef enum int {S_RD, S_HIT, S_IRQ, S_UNL, S_TASK} sel_e;
    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [11:0] adr, input logic [15:0] wd, input logic wr,
                         input logic [15:0] ss);
        @(posedge clk);
        #1;
        ybus.y_adr     = adr;
        ybus.y_wr_data = wd;
        ybus.y_wr      = wr;
        sticky_set     = ss;
    endtask

    task automatic rd(input logic [11:0] adr);
        drive(adr, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic [11:0] adr, input logic [15:0] wd);
        drive(adr, wd, 1'b1, 16'h0);
    endtask

    task automatic expect_v(input sel_e s, input logic [15:0] v, input string n);
        exp_t e;
        e.cyc = cyc;
        e.sel = s;
        e.exp = v;
        e.name = n;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [15:0] got;
            e = sb.pop_front();
            case (e.sel)
                S_RD:    got = ybus.y_rd_data;
                S_HIT:   got = {15'h0, ybus.hit};
                S_IRQ:   got = {15'h0, irq};
                S_UNL:   got = {15'h0, unlocked};
                default: got = task_pulse;
            endcase
            checks++;
            if (e.cyc != cyc || got !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d (queued %0d) got=%h expected=%h", e.name, cyc, e.cyc, got, e.exp);
            end else begin
                $display("ok   %s cyc=%0d value=%h", e.name, cyc, got);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ybus.y_adr = '0;
        ybus.y_wr_data = '0;
        ybus.y_wr = 1'b0;
        sticky_set = '0;

        // Reset state and address map
        repeat (2) rd(12'h000);
        rst_n = 1'b1;
        rd(12'h8C0);
        expect_v(S_RD, 16'h1234, "ctrl0_rst");
        expect_v(S_HIT, 16'h1, "hit_in");
        expect_v(S_IRQ, 16'h0, "irq_rst");
        expect_v(S_UNL, 16'h0, "unl_rst");
        expect_v(S_TASK, 16'h0, "task_rst");
        for (int i = 1; i < 8; i++) begin
            rd(12'h8C0 + 12'(i));
            expect_v(S_RD, 16'h0, $sformatf("ctrl%0d_rst", i));
        end
        rd(12'h8E3); expect_v(S_RD, 16'h0, "lock_rst");
        rd(12'h8D0); expect_v(S_RD, 16'hD001, "stat0");
        rd(12'h8D3); expect_v(S_RD, 16'hD004, "stat3");
        rd(12'hFFF); expect_v(S_HIT, 16'h0, "hit_out"); expect_v(S_RD, 16'h0, "rd_out");
        rd(12'h8E0); expect_v(S_RD, 16'h0, "sticky_rst");

        // Protected write while locked
        wr(12'h8C0, 16'hBEEF);
        rd(12'h8C0); expect_v(S_RD, 16'h1234, "prot_locked");
        rd(12'h8E3); expect_v(S_RD, 16'h0002, "viol_set");
        rd(12'h8E4); expect_v(S_RD, 16'h0000, "cnt_rej");

        // Unlock window: unlocked for exactly T cycles after the key edge
        wr(12'h8E3, 16'hC0DE);
        for (int k = 1; k <= T + 3; k++) begin
            if (k == 1)          wr(12'h8C0, 16'hBEEF);
            else if (k == 2)     rd(12'h8C0);
            else if (k == 3)     rd(12'h8E3);
            else if (k == T)     wr(12'h8C0, 16'hA5A5);
            else if (k == T + 1) wr(12'h8C0, 16'h5555);
            else if (k == T + 2) rd(12'h8C0);
            else                 rd(12'h8E4);
            expect_v(S_UNL, (k <= T) ? 16'h1 : 16'h0, $sformatf("unl_k%0d", k));
            if (k == 2)     expect_v(S_RD, 16'hBEEF, "prot_unlocked");
            if (k == 3)     expect_v(S_RD, 16'h0003, "lock_rd");
            if (k == 4)     expect_v(S_RD, 16'h0002, "cnt_2");
            if (k == T + 2) expect_v(S_RD, 16'hA5A5, "last_cycle_wr");
            if (k == T + 3) expect_v(S_RD, 16'h0003, "cnt_3");
        end
        rd(12'h8E3); expect_v(S_RD, 16'h0002, "viol_relock");
        wr(12'h8E3, 16'h0000);
        rd(12'h8E3); expect_v(S_RD, 16'h0000, "viol_clr");

        // Sticky, mask and irq (count 4 -> 8)
        wr(12'h8E1, 16'h0003);
        drive(12'h8E0, 16'h0, 1'b0, 16'h0001);
        expect_v(S_IRQ, 16'h0, "irq_setcyc");
        rd(12'h8E0); expect_v(S_RD, 16'h0001, "sticky_set"); expect_v(S_IRQ, 16'h1, "irq_set");
        drive(12'h8E0, 16'h0001, 1'b1, 16'h0001);
        rd(12'h8E0); expect_v(S_RD, 16'h0001, "set_wins"); expect_v(S_IRQ, 16'h1, "irq_hold");
        wr(12'h8E0, 16'h0001);
        rd(12'h8E0); expect_v(S_RD, 16'h0000, "w1c"); expect_v(S_IRQ, 16'h0, "irq_clr");
        drive(12'h8E0, 16'h0, 1'b0, 16'h0004);
        rd(12'h8E0); expect_v(S_RD, 16'h0004, "sticky_unmasked"); expect_v(S_IRQ, 16'h0, "irq_masked");
        wr(12'h8E0, 16'h0004);
        rd(12'h8E4); expect_v(S_RD, 16'h0008, "cnt_8");

        // Task pulses, back to back
        wr(12'h8E2, 16'h00A5); expect_v(S_TASK, 16'h0000, "task_pre");
        wr(12'h8E2, 16'h00A5); expect_v(S_TASK, 16'h00A5, "task_p1");
        rd(12'h8E2); expect_v(S_TASK, 16'h00A5, "task_p2"); expect_v(S_RD, 16'h0, "task_rd0");
        rd(12'h8E4); expect_v(S_TASK, 16'h0000, "task_end"); expect_v(S_RD, 16'h000A, "cnt_10");

        // Counter saturation, clear and unmapped writes
        wr(12'h8E4, 16'h1234);
        repeat (65534) wr(12'h8E1, 16'h0003);
        rd(12'h8E4); expect_v(S_RD, 16'hFFFE, "cnt_fffe");
        repeat (3) wr(12'h8E1, 16'h0003);
        rd(12'h8E4); expect_v(S_RD, 16'hFFFF, "cnt_sat");
        wr(12'h8E4, 16'h0000);
        rd(12'h8E4); expect_v(S_RD, 16'h0000, "cnt_clr");
        wr(12'h8E9, 16'h0077);
        rd(12'h8E9); expect_v(S_RD, 16'h0000, "unmapped_rd"); expect_v(S_HIT, 16'h1, "unmapped_hit");
        rd(12'h8E4); expect_v(S_RD, 16'h0000, "cnt_unmapped");

        // Reset mid-unlock, mid-pulse, with sticky pending
        wr(12'h8E3, 16'hC0DE);
        drive(12'h8C0, 16'h1111, 1'b1, 16'h0003);
        rd(12'h8C0); expect_v(S_RD, 16'h1111, "pre_rst_ctrl"); expect_v(S_IRQ, 16'h1, "pre_rst_irq");
        wr(12'h8E2, 16'h5A5A); expect_v(S_UNL, 16'h1, "pre_rst_unl");
        drive(12'h8C1, 16'h9999, 1'b1, 16'h0008);
        rst_n = 1'b0;
        expect_v(S_TASK, 16'h5A5A, "pre_rst_task");
        rd(12'h8C0);
        rst_n = 1'b1;
        expect_v(S_RD, 16'h1234, "rst_ctrl0");
        expect_v(S_UNL, 16'h0, "rst_unl");
        expect_v(S_IRQ, 16'h0, "rst_irq");
        expect_v(S_TASK, 16'h0, "rst_task");
        rd(12'h8E0); expect_v(S_RD, 16'h0000, "rst_sticky");
        rd(12'h8C1); expect_v(S_RD, 16'h0000, "rst_wr_ignored");
        rd(12'h8E4); expect_v(S_RD, 16'h0000, "rst_cnt");

        repeat (2) rd(12'h000);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard: %0d expectations never checked, expected 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/crs_reg_bank.md
Name: crs_reg_bank

Overview:
- Parametrised register-bank slave on the crs_master y-bus (y_adr / y_wr_data / y_wr / y_rd_data).
- Successor to the fixed single-register decode in the top-level register block.
- Provides N_CTRL control registers, N_STAT live status registers, a sticky event register with mask and IRQ, self-clearing task pulses, a key-based write-protect lock with timeout, and a saturating write counter.
- Instantiated alongside the scratch DPRAM. The parent muxes y_rd_data using the hit output.

Parameters:
ADR_W, 12, y-bus address width
DATA_W, 16, y-bus data width (>=8)
BASE_ADR, 12'h8C0, region base; must be 64-word aligned
N_CTRL, 8, control register count (1..16)
N_STAT, 4, status register count (1..16)
CTRL_RST, all zeros, N_CTRL*DATA_W reset values, reg i at bits [i*DATA_W +: DATA_W]
PROT_MASK, 0, N_CTRL-bit mask; bit i set = ctrl i write-protected
UNLOCK_KEY, 16'hC0DE, lock-register value that unlocks
LOCK_TIMEOUT, 1024, cycles an unlock remains valid (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
y_adr  in  ADR_W  bus address
y_wr_data  in  DATA_W  bus write data
y_wr  in  1  write strobe, one cycle per write
y_rd_data  out  DATA_W  combinational read data
hit  out  1  combinational, y_adr inside region
ctrl_out  out  N_CTRL*DATA_W  control register contents
stat_in  in  N_STAT*DATA_W  live status, read-only
sticky_set  in  DATA_W  per-bit event set pulses
task_pulse  out  DATA_W  one-cycle task strobes
irq  out  1  registered, masked sticky OR
unlocked  out  1  lock state

Behaviour:
Region and address map:
- Region is y_adr[ADR_W-1:6] == BASE_ADR[ADR_W-1:6]. off = y_adr[5:0].
- hit=1 inside the region. Outside: hit=0, y_rd_data=0, writes ignored.
- off 0x00..N_CTRL-1: ctrl[i], R/W.
- off 0x10..0x10+N_STAT-1: stat_in[j], RO.
- 0x20: sticky, R/W1C.
- 0x21: mask, R/W.
- 0x22: task, WO, reads 0.
- 0x23: lock. Read = {0.., viol, unlocked}.
- 0x24: wr_count. Write of any value clears it.
- Unimplemented offsets read 0; writes to them are ignored and not counted.
- Reads are combinational from registered state plus stat_in. Zero latency, no read side effects.

Writes:
- All writes take effect on the clk edge with y_wr=1. New value is visible on the next cycle.

Lock:
- Write UNLOCK_KEY to 0x23: unlocked<=1, timer<=LOCK_TIMEOUT-1.
- Any other value written to 0x23: unlocked<=0, viol<=0.
- While unlocked, the timer decrements every cycle; unlocked<=0 on the cycle the timer is 0.
- A re-key while unlocked reloads the timer.
- Write to ctrl[i] with PROT_MASK[i]=1 while locked: register unchanged, viol<=1, not counted.
- A write landing on the final unlocked cycle is accepted.

Task:
- Write to 0x22: task_pulse <= y_wr_data on the next edge. task_pulse returns to 0 after exactly one cycle.
- Back-to-back writes give back-to-back pulses.

Sticky:
- sticky <= (sticky & ~w1c) | sticky_set, where w1c = y_wr_data on a write to 0x20, else 0.
- Set wins over a simultaneous clear.
- irq <= |(sticky_next & mask_next). IRQ asserts one cycle after the set edge.

wr_count:
- +1 per accepted write in region, including writes to 0x23, 0x22 and 0x20.
- Saturates at all-ones.
- Clear write wins; the clearing write is not counted.

Reset (rst_n=0 at a clk edge), any time including mid-unlock or mid-pulse:
- ctrl=CTRL_RST, mask=0, sticky=0, task_pulse=0, irq=0, unlocked=0, viol=0, timer=0, wr_count=0.
- Writes during reset are ignored. Sticky sets during reset are dropped.

Test Plan:
- Reset, then read 0x8C0..0x8C7 with CTRL_RST[15:0]=16'h1234 → 0x8C0 reads 1234, others 0. Read 0x8E3 → 0. irq=0, hit=1; y_adr=0xFFF → hit=0.
- PROT_MASK=8'h01:
  - Write 0x8C0=0xBEEF while locked → reads 1234, 0x8E3 bit1=1.
  - Write 0x8E3=0xC0DE, then 0x8C0=0xBEEF → reads BEEF.
  - Wait LOCK_TIMEOUT cycles → unlocked=0.
  - Write 0x8C0=0x5555 → unchanged.
- Set mask=0x0003 and pulse sticky_set=0x0001 → sticky=0x0001, irq=1 one cycle later. Then write 0x8E0=0x0001 on the same edge as sticky_set=0x0001 → sticky stays 0x0001.
- Write 0x8E2=0x00A5 twice on consecutive cycles → task_pulse=00A5 for exactly two cycles, then 0.
- 65537 accepted writes → wr_count=FFFF (saturated). Write 0x8E4 → 0. One write to unmapped 0x8E9 → count stays 0.
- Assert rst_n=0 for one cycle mid-unlock with sticky=0x0003 → unlocked=0, sticky=0, irq=0, ctrl back to CTRL_RST.
